// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard control unit: forwarding selects, FSM
// states and the bundled stall/flush control word.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard control unit (slave).
interface hazard_control_unit_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] Rs1D;
    logic [ADDR_WIDTH-1:0] Rs2D;
    logic [ADDR_WIDTH-1:0] Rs1E;
    logic [ADDR_WIDTH-1:0] Rs2E;
    logic [ADDR_WIDTH-1:0] RdE;
    logic [ADDR_WIDTH-1:0] RdM;
    logic [ADDR_WIDTH-1:0] RdW;
    logic                  ResultSrcE0;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  PCSrcE;
    logic                  MemReqM;
    logic                  MemReadyM;
    logic                  CntClr;

    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  StallM;
    logic                  FlushD;
    logic                  FlushE;
    logic                  FlushW;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic                  MemTimeout;
    logic [CNT_WIDTH-1:0]  StallCycles;
    logic [CNT_WIDTH-1:0]  LwStallCnt;
    logic [CNT_WIDTH-1:0]  FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CntClr,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemTimeout, StallCycles, LwStallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CntClr,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemTimeout, StallCycles, LwStallCnt, FlushCnt
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Event counter that saturates at all-ones; synchronous clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: forwarding selects, prioritised stall/flush decode,
// memory-wait tracking with timeout watchdog, and saturating event counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave hz
);

    localparam int unsigned            WaitWidth = $clog2(TIMEOUT + 1);
    localparam logic [WaitWidth-1:0]   WaitMax   = WaitWidth'(TIMEOUT);

    function automatic fwd_sel_t fwd_sel(input logic [ADDR_WIDTH-1:0] rs,
                                         input logic [ADDR_WIDTH-1:0] rd_m,
                                         input logic [ADDR_WIDTH-1:0] rd_w,
                                         input logic                  wr_m,
                                         input logic                  wr_w);
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_NONE;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);

    logic mem_haz;
    logic lw_haz;
    logic lw_win;
    logic flush_win;

    assign mem_haz   = hz.MemReqM & ~hz.MemReadyM;
    assign lw_haz    = hz.ResultSrcE0 & (hz.RdE != '0) &
                       ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
    assign flush_win = hz.PCSrcE & ~mem_haz;
    assign lw_win    = lw_haz & ~hz.PCSrcE & ~mem_haz;

    // Decoded from mem_haz rather than state, so a same-cycle ready costs no stall.
    hz_ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        if (mem_haz) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (lw_haz) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    assign hz.StallF = ctrl.stall_f;
    assign hz.StallD = ctrl.stall_d;
    assign hz.StallE = ctrl.stall_e;
    assign hz.StallM = ctrl.stall_m;
    assign hz.FlushD = ctrl.flush_d;
    assign hz.FlushE = ctrl.flush_e;
    assign hz.FlushW = ctrl.flush_w;

    hz_state_t            state_q, state_d;
    logic [WaitWidth-1:0] wait_q, wait_d;
    logic                 timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_haz) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!hz.MemReqM) begin
                    // Request dropped without ready: protocol violation.
                    timeout_d = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end else if (hz.MemReadyM) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q != WaitMax) begin
                    wait_d = wait_q + WaitWidth'(1);
                    if (wait_d == WaitMax) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.MemTimeout = timeout_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.CntClr),
        .inc   (mem_haz),
        .count (hz.StallCycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_lw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.CntClr),
        .inc   (lw_win),
        .count (hz.LwStallCnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.CntClr),
        .inc   (flush_win),
        .count (hz.FlushCnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_hazard_control_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;
    localparam int unsigned TO = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    hazard_control_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    hazard_control_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_sc, m_lc, m_fc;

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          ld, rwm, rww, pc, req, rdy;
        logic [6:0]    ctl;
        logic [1:0]    fa, fb;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] act_ctl();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                bus.FlushD, bus.FlushE, bus.FlushW};
    endfunction

    function automatic bit m_memhaz();
        return bus.MemReqM && !bus.MemReadyM;
    endfunction

    function automatic bit m_lwhaz();
        return bus.ResultSrcE0 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    endfunction

    function automatic logic [6:0] exp_ctl();
        if (m_memhaz()) return 7'b1111_001;
        if (bus.PCSrcE) return 7'b0000_110;
        if (m_lwhaz())  return 7'b1100_010;
        return 7'b0;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'd2;
        if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0;
        m_sc = 0; m_lc = 0; m_fc = 0;
    endtask

    task automatic model_tick();
        bit mh, lw;
        mh = m_memhaz();
        lw = m_lwhaz();
        if (bus.CntClr) begin
            m_sc = 0; m_lc = 0; m_fc = 0;
        end else if (mh) m_sc = sat(m_sc + 1);
        else if (bus.PCSrcE) m_fc = sat(m_fc + 1);
        else if (lw) m_lc = sat(m_lc + 1);
        if (!m_wait) begin
            if (mh) begin m_wait = 1; m_wcnt = 0; end
        end else if (!bus.MemReqM) begin
            m_to = 1; m_wait = 0;
        end else if (bus.MemReadyM) begin
            m_wait = 0;
        end else begin
            m_wcnt++;
            if (m_wcnt >= TO) m_to = 1;
        end
    endtask

    task automatic step();
        if (rst_n) model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
        bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
        bus.ResultSrcE0 = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.PCSrcE = 0; bus.MemReqM = 0; bus.MemReadyM = 0; bus.CntClr = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.Rs1D = v.rs1d; bus.Rs2D = v.rs2d; bus.Rs1E = v.rs1e; bus.Rs2E = v.rs2e;
        bus.RdE = v.rde; bus.RdM = v.rdm; bus.RdW = v.rdw;
        bus.ResultSrcE0 = v.ld; bus.RegWriteM = v.rwm; bus.RegWriteW = v.rww;
        bus.PCSrcE = v.pc; bus.MemReqM = v.req; bus.MemReadyM = v.rdy;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_stallcycles"}, bus.StallCycles, m_sc);
        check({tag, "_lwstallcnt"}, bus.LwStallCnt, m_lc);
        check({tag, "_flushcnt"}, bus.FlushCnt, m_fc);
        check({tag, "_memtimeout"}, bus.MemTimeout, m_to);
    endtask

    initial begin
        //            rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww pc req rdy ctl         fa    fb
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000_000, 2'd0, 2'd0};
        tbl[1]  = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1100_010, 2'd0, 2'd0};
        tbl[2]  = '{1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1100_010, 2'd0, 2'd0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b0000_000, 2'd0, 2'd0};
        tbl[4]  = '{5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000_000, 2'd0, 2'd0};
        tbl[5]  = '{0, 0, 3, 4, 0, 3, 3, 0, 1, 1, 0, 0, 0, 7'b0000_000, 2'd2, 2'd0};
        tbl[6]  = '{0, 0, 3, 4, 0, 3, 3, 0, 0, 1, 0, 0, 0, 7'b0000_000, 2'd1, 2'd0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 7'b0000_000, 2'd0, 2'd0};
        tbl[8]  = '{0, 0, 2, 9, 0, 2, 9, 0, 1, 1, 0, 0, 0, 7'b0000_000, 2'd2, 2'd1};
        tbl[9]  = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 7'b0000_110, 2'd0, 2'd0};
        tbl[10] = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 0, 7'b1111_001, 2'd0, 2'd0};
        tbl[11] = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 1, 7'b0000_110, 2'd0, 2'd0};

        clear_inputs();
        rst_n = 1'b1;
        #2;
        do_reset();
        check_regs("reset");

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            #1;
            check($sformatf("vec%0d_ctl", i), act_ctl(), tbl[i].ctl);
            check($sformatf("vec%0d_fa", i), bus.ForwardAE, tbl[i].fa);
            check($sformatf("vec%0d_fb", i), bus.ForwardBE, tbl[i].fb);
            step();
        end

        // Load-use, then a load to x0
        do_reset();
        bus.ResultSrcE0 = 1; bus.RdE = 5; bus.Rs1D = 5;
        #1;
        check("lw_ctl", act_ctl(), 7'b1100_010);
        step();
        check("lw_cnt", bus.LwStallCnt, 1);
        bus.RdE = 0; bus.Rs1D = 0;
        #1;
        check("lw_x0_ctl", act_ctl(), 7'b0);
        step();
        check("lw_x0_cnt", bus.LwStallCnt, 1);

        // Branch beats load-use
        bus.RdE = 5; bus.Rs1D = 5; bus.PCSrcE = 1;
        #1;
        check("pc_lw_ctl", act_ctl(), 7'b0000_110);
        step();
        check("pc_lw_flushcnt", bus.FlushCnt, 1);
        check("pc_lw_lwcnt", bus.LwStallCnt, 1);
        clear_inputs();

        // Four-cycle memory wait
        bus.MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wait%0d_ctl", i), act_ctl(), 7'b1111_001);
            step();
        end
        bus.MemReadyM = 1;
        #1;
        check("wait_ready_ctl", act_ctl(), 7'b0);
        step();
        check("wait_stallcycles", bus.StallCycles, 4);
        clear_inputs();
        step();
        check("wait_back_to_run", bus.MemTimeout, 0);

        // Ready in the request cycle: no stall
        bus.MemReqM = 1; bus.MemReadyM = 1;
        #1;
        check("same_cycle_ctl", act_ctl(), 7'b0);
        step();
        clear_inputs();
        step();
        check("same_cycle_stallcycles", bus.StallCycles, 4);
        check("same_cycle_timeout", bus.MemTimeout, 0);

        // Branch held off by memory wait, flushes on the ready cycle
        bus.MemReqM = 1; bus.PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("pcwait%0d_flushd", i), bus.FlushD, 0);
            check($sformatf("pcwait%0d_flushe", i), bus.FlushE, 0);
            check($sformatf("pcwait%0d_stallf", i), bus.StallF, 1);
            step();
        end
        bus.MemReadyM = 1;
        #1;
        check("pcwait_ready_ctl", act_ctl(), 7'b0000_110);
        step();
        check("pcwait_flushcnt", bus.FlushCnt, 2);
        check("pcwait_stallcycles", bus.StallCycles, 6);
        clear_inputs();
        step();

        // Timeout watchdog, CntClr, asynchronous reset mid-wait
        bus.MemReqM = 1;
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            check($sformatf("to_edge%0d", k), bus.MemTimeout, (k == TO + 1));
        end
        step();
        step();
        check("to_sticky", bus.MemTimeout, 1);
        bus.CntClr = 1;
        step();
        bus.CntClr = 0;
        check("clr_stallcycles", bus.StallCycles, 0);
        check("clr_flushcnt", bus.FlushCnt, 0);
        check("clr_keeps_timeout", bus.MemTimeout, 1);
        step();
        check("post_clr_stallcycles", bus.StallCycles, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_timeout", bus.MemTimeout, 0);
        check("async_rst_stallcycles", bus.StallCycles, 0);
        bus.MemReqM = 0;
        #1;
        rst_n = 1'b1;
        step();
        check("async_rst_run", bus.MemTimeout, 0);

        // Saturation
        bus.PCSrcE = 1;
        for (int i = 0; i < CMAX + 6; i++) step();
        check("sat_flushcnt", bus.FlushCnt, CMAX);
        clear_inputs();

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.Rs1D = AW'($urandom_range(0, 3)); bus.Rs2D = AW'($urandom_range(0, 3));
            bus.Rs1E = AW'($urandom_range(0, 3)); bus.Rs2E = AW'($urandom_range(0, 3));
            bus.RdE = AW'($urandom_range(0, 3)); bus.RdM = AW'($urandom_range(0, 3));
            bus.RdW = AW'($urandom_range(0, 3));
            bus.ResultSrcE0 = 1'($urandom_range(0, 1));
            bus.RegWriteM = 1'($urandom_range(0, 1));
            bus.RegWriteW = 1'($urandom_range(0, 1));
            bus.PCSrcE = ($urandom_range(0, 3) == 0);
            bus.MemReqM = ($urandom_range(0, 7) != 0);
            bus.MemReadyM = ($urandom_range(0, 2) == 0);
            bus.CntClr = ($urandom_range(0, 63) == 0);
            if (i == 1500) begin
                m_to = 0;
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
            end
            #1;
            check("rnd_ctl", act_ctl(), exp_ctl());
            check("rnd_fa", bus.ForwardAE, exp_fwd(bus.Rs1E));
            check("rnd_fb", bus.ForwardBE, exp_fwd(bus.Rs2E));
            step();
            check_regs("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Produces the stall, flush and forwarding controls that drive the pipeline registers. Its outputs feed the stage registers directly, for example FlushE goes to the clear input of the decode-to-execute register. It detects load-use hazards, taken branches and jumps, and multi-cycle data-memory waits, and resolves them in a fixed priority. It also tracks memory-wait state, a timeout watchdog and saturating performance counters.

Parameters:
ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, width of each performance counter
TIMEOUT, 256, memory-wait cycles before MemTimeout is raised

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Rs1D  in  ADDR_WIDTH  source 1 of the instruction in D
Rs2D  in  ADDR_WIDTH  source 2 of the instruction in D
Rs1E  in  ADDR_WIDTH  source 1 of the instruction in E
Rs2E  in  ADDR_WIDTH  source 2 of the instruction in E
RdE  in  ADDR_WIDTH  destination of the instruction in E
RdM  in  ADDR_WIDTH  destination of the instruction in M
RdW  in  ADDR_WIDTH  destination of the instruction in W
ResultSrcE0  in  1  instruction in E is a load
RegWriteM  in  1  instruction in M writes the register file
RegWriteW  in  1  instruction in W writes the register file
PCSrcE  in  1  branch taken or jump in E
MemReqM  in  1  data memory access in M
MemReadyM  in  1  data memory completes this cycle
CntClr  in  1  synchronous clear of the counters
StallF  out  1  hold the PC
StallD  out  1  hold the fetch-to-decode register
StallE  out  1  hold the decode-to-execute register
StallM  out  1  hold the execute-to-memory register
FlushD  out  1  clear the fetch-to-decode register
FlushE  out  1  clear the decode-to-execute register
FlushW  out  1  clear the memory-to-writeback register (inserts a bubble)
ForwardAE  out  2  operand A select in E
ForwardBE  out  2  operand B select in E
MemTimeout  out  1  sticky error flag
StallCycles  out  CNT_WIDTH  cycles spent in memory wait
LwStallCnt  out  CNT_WIDTH  load-use stall events
FlushCnt  out  CNT_WIDTH  branch/jump flush events

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=RUN; all counters=0; MemTimeout=0; wait counter=0.
- Forwarding (combinational, no latency), shown for ForwardAE; ForwardBE is identical using Rs2E:
  - 2'b10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - else 2'b01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - else 2'b00.
  - The M stage takes priority over W.
- Hazard conditions:
  - lwHaz = ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
  - memHaz = MemReqM and not MemReadyM.
- Priority, highest first:
  - memHaz: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Every stage holds, including any pending branch.
  - PCSrcE: FlushD=FlushE=1, no stalls. A load-use hazard in the same cycle is discarded because its D instruction is squashed.
  - lwHaz: StallF=StallD=1, FlushE=1.
  - Otherwise: all controls 0.
- FSM:
  - RUN to MEM_WAIT when memHaz.
  - MEM_WAIT to RUN in the cycle MemReadyM=1.
  - Stall outputs are decoded from memHaz (combinational), not from the state. A ready returned in the same cycle as the request therefore causes zero stall.
  - Every MemReqM=0 while in MEM_WAIT counts as a protocol error: sets MemTimeout, FSM returns to RUN.
- Wait counter:
  - Increments each MEM_WAIT cycle; cleared on entry to RUN.
  - On reaching TIMEOUT: MemTimeout set (sticky until reset); FSM stays in MEM_WAIT.
- Counters:
  - Registered and saturate at all-ones; no wrap.
  - StallCycles increments on each cycle with memHaz.
  - LwStallCnt increments on each cycle where lwHaz is the winning condition.
  - FlushCnt increments on each cycle where PCSrcE is the winning condition.
  - CntClr has priority over increment; the counters read 0 on the next cycle.
  - CntClr does not clear MemTimeout.
- rst_n asserted mid-wait: returns to RUN immediately; all outputs revert to their reset/combinational values.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - hz_state_t enum: RUN, MEM_WAIT.
- Natural sub-module: sat_counter (parameter WIDTH; inputs clk, rst_n, clr, inc; output count), instantiated three times.

Test Plan:
- lw x5 in E, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle; LwStallCnt 0 to 1; an RdE=0 load causes no stall.
- RdM=3 with RegWriteM=1, RdW=3 with RegWriteW=1, Rs1E=3 -> ForwardAE=2'b10. Drop RegWriteM -> ForwardAE=2'b01. RdM=RdW=0 -> ForwardAE=2'b00.
- PCSrcE=1 together with lwHaz -> FlushD=FlushE=1, StallF=0; FlushCnt increments, LwStallCnt unchanged.
- MemReqM=1, MemReadyM held 0 for 4 cycles, then 1:
  - all four stalls and FlushW high for exactly 4 cycles; StallCycles=4; FSM back to RUN.
  - repeat with ready in the same cycle as the request: 0 stall cycles.
- PCSrcE=1 during a memory wait -> FlushD=FlushE stay 0 until ready; the flush then occurs on the ready cycle.
- TIMEOUT=8, MemReadyM never asserted -> MemTimeout rises after 8 wait cycles and stays set through CntClr; rst_n low mid-wait clears all state asynchronously.
